// File: rtl/cell_grid_pkg.sv
// Shared grid geometry, widths and controller state encoding for cell selection.
package cell_grid_pkg;

   localparam int unsigned CELL_W    = 48;
   localparam int unsigned CELL_H    = 64;
   localparam int unsigned GRID_COLS = 10;
   localparam int unsigned GRID_ROWS = 10;

   localparam int unsigned X_LIMIT = CELL_W * GRID_COLS;
   localparam int unsigned Y_LIMIT = CELL_H * GRID_ROWS;

   localparam int unsigned COORD_W = 10;
   localparam int unsigned IDX_W   = 4;

   typedef enum logic [2:0] {
      StIdle,
      StDivX,
      StDivY,
      StUpdate,
      StClick
   } state_e;

   // True when the pixel falls inside the playable grid area.
   function automatic logic in_grid(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
      return (x < COORD_W'(X_LIMIT)) && (y < COORD_W'(Y_LIMIT));
   endfunction

endpackage

// File: rtl/cell_axis_div.sv
// Iterative subtract-compare divider shared by both axes; one subtraction per step.
module cell_axis_div
   import cell_grid_pkg::*;
(
   input  logic               clk_in,
   input  logic               rst_n_in,
   input  logic               load_in,
   input  logic [COORD_W-1:0] load_val_in,
   input  logic               sel_row_in,
   input  logic               step_in,
   output logic               done_out,
   output logic [IDX_W-1:0]   q_out
);

   logic [COORD_W-1:0] rem_q, rem_d;
   logic [IDX_W-1:0]   q_q, q_d;
   logic [COORD_W-1:0] divisor;

   // Divisor select, completion flag and next remainder/quotient.
   always_comb begin
      divisor  = sel_row_in ? COORD_W'(CELL_H) : COORD_W'(CELL_W);
      done_out = (rem_q < divisor);
      rem_d    = rem_q;
      q_d      = q_q;
      if (load_in) begin
         rem_d = load_val_in;
         q_d   = '0;
      end else if (step_in && !done_out) begin
         // Quotient cannot exceed 9 because inputs are pre-filtered by in_grid.
         rem_d = rem_q - divisor;
         q_d   = q_q + IDX_W'(1);
      end
   end

   // Remainder and quotient registers.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         rem_q <= '0;
         q_q   <= '0;
      end else begin
         rem_q <= rem_d;
         q_q   <= q_d;
      end
   end

   assign q_out = q_q;

endmodule

// File: rtl/cell_select_ctrl.sv
// Converts mouse samples into hover cell and one-shot click events via a shared divider.
module cell_select_ctrl
   import cell_grid_pkg::*;
(
   input  logic               clk_in,
   input  logic               rst_n_in,
   input  logic               pos_valid_in,
   output logic               pos_ready_out,
   input  logic [COORD_W-1:0] pos_x_in,
   input  logic [COORD_W-1:0] pos_y_in,
   input  logic               btn_left_in,
   output logic [IDX_W-1:0]   hover_col_out,
   output logic [IDX_W-1:0]   hover_row_out,
   output logic               hover_valid_out,
   output logic               click_valid_out,
   input  logic               click_ready_in,
   output logic [IDX_W-1:0]   click_col_out,
   output logic [IDX_W-1:0]   click_row_out
);

   state_e             state_q, state_d;
   logic [COORD_W-1:0] y_q, y_d;
   logic               in_grid_q, in_grid_d;
   logic               press_q, press_d;
   logic               btn_prev_q, btn_prev_d;
   logic [IDX_W-1:0]   col_q, col_d;
   logic [IDX_W-1:0]   row_q, row_d;
   logic [IDX_W-1:0]   hover_col_q, hover_col_d;
   logic [IDX_W-1:0]   hover_row_q, hover_row_d;
   logic               hover_valid_q, hover_valid_d;
   logic               click_valid_q, click_valid_d;
   logic [IDX_W-1:0]   click_col_q, click_col_d;
   logic [IDX_W-1:0]   click_row_q, click_row_d;

   logic               div_load;
   logic [COORD_W-1:0] div_val;
   logic               div_sel_row;
   logic               div_step;
   logic               div_done;
   logic [IDX_W-1:0]   div_q;
   logic               sample_in_grid;

   cell_axis_div u_div (
      .clk_in      (clk_in),
      .rst_n_in    (rst_n_in),
      .load_in     (div_load),
      .load_val_in (div_val),
      .sel_row_in  (div_sel_row),
      .step_in     (div_step),
      .done_out    (div_done),
      .q_out       (div_q)
   );

   // Next-state logic: accept sample, divide x then y, publish, optionally hold a click.
   always_comb begin
      state_d        = state_q;
      y_d            = y_q;
      in_grid_d      = in_grid_q;
      press_d        = press_q;
      btn_prev_d     = btn_prev_q;
      col_d          = col_q;
      row_d          = row_q;
      hover_col_d    = hover_col_q;
      hover_row_d    = hover_row_q;
      hover_valid_d  = hover_valid_q;
      click_valid_d  = click_valid_q;
      click_col_d    = click_col_q;
      click_row_d    = click_row_q;
      div_load       = 1'b0;
      div_val        = pos_x_in;
      div_sel_row    = 1'b0;
      div_step       = 1'b0;
      sample_in_grid = in_grid(pos_x_in, pos_y_in);

      case (state_q)
         StIdle: begin
            if (pos_valid_in) begin
               y_d        = pos_y_in;
               in_grid_d  = sample_in_grid;
               press_d    = btn_left_in && !btn_prev_q;
               // Edge history advances even for out-of-grid samples.
               btn_prev_d = btn_left_in;
               if (sample_in_grid) begin
                  div_load = 1'b1;
                  div_val  = pos_x_in;
                  state_d  = StDivX;
               end else begin
                  state_d = StUpdate;
               end
            end
         end
         StDivX: begin
            div_sel_row = 1'b0;
            div_step    = 1'b1;
            if (div_done) begin
               col_d    = div_q;
               div_load = 1'b1;
               div_val  = y_q;
               state_d  = StDivY;
            end
         end
         StDivY: begin
            div_sel_row = 1'b1;
            div_step    = 1'b1;
            if (div_done) begin
               row_d   = div_q;
               state_d = StUpdate;
            end
         end
         StUpdate: begin
            hover_valid_d = in_grid_q;
            if (in_grid_q) begin
               hover_col_d = col_q;
               hover_row_d = row_q;
            end
            if (press_q && in_grid_q) begin
               click_col_d   = col_q;
               click_row_d   = row_q;
               click_valid_d = 1'b1;
               state_d       = StClick;
            end else begin
               state_d = StIdle;
            end
         end
         StClick: begin
            if (click_ready_in) begin
               click_valid_d = 1'b0;
               state_d       = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers; reset drops any pending click.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q       <= StIdle;
         y_q           <= '0;
         in_grid_q     <= 1'b0;
         press_q       <= 1'b0;
         btn_prev_q    <= 1'b0;
         col_q         <= '0;
         row_q         <= '0;
         hover_col_q   <= '0;
         hover_row_q   <= '0;
         hover_valid_q <= 1'b0;
         click_valid_q <= 1'b0;
         click_col_q   <= '0;
         click_row_q   <= '0;
      end else begin
         state_q       <= state_d;
         y_q           <= y_d;
         in_grid_q     <= in_grid_d;
         press_q       <= press_d;
         btn_prev_q    <= btn_prev_d;
         col_q         <= col_d;
         row_q         <= row_d;
         hover_col_q   <= hover_col_d;
         hover_row_q   <= hover_row_d;
         hover_valid_q <= hover_valid_d;
         click_valid_q <= click_valid_d;
         click_col_q   <= click_col_d;
         click_row_q   <= click_row_d;
      end
   end

   assign pos_ready_out   = (state_q == StIdle);
   assign hover_col_out   = hover_col_q;
   assign hover_row_out   = hover_row_q;
   assign hover_valid_out = hover_valid_q;
   assign click_valid_out = click_valid_q;
   assign click_col_out   = click_col_q;
   assign click_row_out   = click_row_q;

endmodule

// File: tb/tb_cell_select_ctrl.sv
// Directed plus randomized bench for cell_select_ctrl against an arithmetic reference model.
module tb_cell_select_ctrl;

   logic       clk;
   logic       rst_n;
   logic       pos_valid;
   logic       pos_ready;
   logic [9:0] pos_x;
   logic [9:0] pos_y;
   logic       btn;
   logic [3:0] hover_col;
   logic [3:0] hover_row;
   logic       hover_valid;
   logic       click_valid;
   logic       click_ready;
   logic [3:0] click_col;
   logic [3:0] click_row;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   int m_col   = 0;
   int m_row   = 0;
   int m_valid = 0;
   int m_prev  = 0;

   cell_select_ctrl dut (
      .clk_in          (clk),
      .rst_n_in        (rst_n),
      .pos_valid_in    (pos_valid),
      .pos_ready_out   (pos_ready),
      .pos_x_in        (pos_x),
      .pos_y_in        (pos_y),
      .btn_left_in     (btn),
      .hover_col_out   (hover_col),
      .hover_row_out   (hover_row),
      .hover_valid_out (hover_valid),
      .click_valid_out (click_valid),
      .click_ready_in  (click_ready),
      .click_col_out   (click_col),
      .click_row_out   (click_row)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_hover(input string tag);
      chk({tag, "_hcol"}, 32'(hover_col), 32'(m_col));
      chk({tag, "_hrow"}, 32'(hover_row), 32'(m_row));
      chk({tag, "_hval"}, 32'(hover_valid), 32'(m_valid));
   endtask

   // Sends one sample starting at a negedge, checks latency, hover and click handshake.
   task automatic do_sample(input int x, input int y, input int b, input int hold);
      int  t;
      int  ing;
      int  ec;
      int  er;
      int  lat;
      int  click;
      t = 0;
      while (!pos_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("ready_wait", 32'(t < 100), 32'd1);
      ing   = (x < 480 && y < 640) ? 1 : 0;
      ec    = x / 48;
      er    = y / 64;
      click = (b == 1 && m_prev == 0 && ing == 1) ? 1 : 0;
      m_prev = b;
      lat   = ing ? (ec + er + 3) : 1;
      pos_valid = 1'b1;
      pos_x     = 10'(x);
      pos_y     = 10'(y);
      btn       = b[0];
      @(posedge clk);
      @(negedge clk);
      pos_valid = 1'b0;
      for (int j = 0; j < lat; j++) begin
         if (j == 0 || j == lat - 1) begin
            chk_hover("busy");
            chk("busy_ready", 32'(pos_ready), 32'd0);
            chk("busy_click", 32'(click_valid), 32'd0);
         end
         @(negedge clk);
      end
      m_valid = ing;
      if (ing) begin
         m_col = ec;
         m_row = er;
      end
      chk_hover("upd");
      chk("upd_click", 32'(click_valid), 32'(click));
      chk("upd_ready", 32'(pos_ready), 32'(click == 0));
      if (click) begin
         chk("click_col", 32'(click_col), 32'(ec));
         chk("click_row", 32'(click_row), 32'(er));
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 32'(click_valid), 32'd1);
            chk("hold_col", 32'(click_col), 32'(ec));
            chk("hold_row", 32'(click_row), 32'(er));
            chk("hold_ready", 32'(pos_ready), 32'd0);
         end
         click_ready = 1'b1;
         @(negedge clk);
         click_ready = 1'b0;
         chk("hs_valid", 32'(click_valid), 32'd0);
         chk("hs_ready", 32'(pos_ready), 32'd1);
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      pos_valid   = 1'b0;
      pos_x       = '0;
      pos_y       = '0;
      btn         = 1'b0;
      click_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset state
      chk("rst_ready", 32'(pos_ready), 32'd1);
      chk_hover("rst");
      chk("rst_click", 32'(click_valid), 32'd0);
      chk("rst_ccol", 32'(click_col), 32'd0);
      chk("rst_crow", 32'(click_row), 32'd0);

      // Directed corner samples
      do_sample(0, 0, 0, 0);
      do_sample(479, 639, 0, 0);
      do_sample(480, 10, 0, 0);
      do_sample(100, 130, 1, 5);
      do_sample(200, 200, 1, 0);   // held button: no second click
      do_sample(300, 300, 0, 0);
      do_sample(47, 63, 1, 0);     // immediate click handshake
      do_sample(48, 64, 0, 0);
      do_sample(5, 640, 1, 0);     // out-of-grid press discarded
      do_sample(10, 10, 1, 2);     // still held: no click

      // Randomized samples
      for (int i = 0; i < 40; i++) begin
         do_sample(int'($urandom_range(0, 560)), int'($urandom_range(0, 720)),
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      end
      do_sample(0, 0, 0, 0);

      // Reset asserted while dividing y for a pressed in-grid sample
      pos_valid = 1'b1;
      pos_x     = 10'd479;
      pos_y     = 10'd639;
      btn       = 1'b1;
      @(posedge clk);
      @(negedge clk);
      pos_valid = 1'b0;
      repeat (12) @(negedge clk);
      rst_n = 1'b0;
      #1;
      m_col   = 0;
      m_row   = 0;
      m_valid = 0;
      m_prev  = 0;
      chk("mid_rst_ready", 32'(pos_ready), 32'd1);
      chk_hover("mid_rst");
      chk("mid_rst_click", 32'(click_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (25) @(negedge clk);
      chk("post_rst_click", 32'(click_valid), 32'd0);
      chk("post_rst_ready", 32'(pos_ready), 32'd1);
      chk_hover("post_rst");

      // Button held from before reset counts as a fresh press
      do_sample(150, 200, 1, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cell_select_ctrl.md
# cell_select_ctrl

Sequencing controller between the mouse position source and the game-board logic. Accepts position/button samples over a valid/ready handshake and converts them to a grid cell with one shared iterative subtract-divider, time-multiplexed across both axes. Presents the current hover cell continuously and issues one click event per left-button press over a valid/ready handshake. Sits downstream of the mouse packet decoder and upstream of the board state and VGA overlay.

## Interface
- CELL_W, 48, cell width in pixels along x; selects the column.
- CELL_H, 64, cell height in pixels along y; selects the row.
- GRID_COLS, 10, columns; x grid limit is CELL_W*GRID_COLS = 480.
- GRID_ROWS, 10, rows; y grid limit is CELL_H*GRID_ROWS = 640.
- clk_in  in  1  system clock; single clock domain.
- rst_n_in  in  1  asynchronous, active-low reset.
- pos_valid_in  in  1  position sample valid.
- pos_ready_out  out  1  high only in IDLE.
- pos_x_in  in  10  pixel x, unsigned.
- pos_y_in  in  10  pixel y, unsigned.
- btn_left_in  in  1  left-button level for this sample.
- hover_col_out  out  4  column = x / CELL_W.
- hover_row_out  out  4  row = y / CELL_H.
- hover_valid_out  out  1  last accepted sample was inside the grid.
- click_valid_out  out  1  click event pending.
- click_ready_in  in  1  consumer accepts the click.
- click_col_out  out  4  column of the pending click.
- click_row_out  out  4  row of the pending click.

## Operation
- States are IDLE, DIV_X, DIV_Y, UPDATE and CLICK.
- IDLE:
  - On pos_valid_in && pos_ready_out, latch x, y and btn.
  - Compute in_grid = (x < 480) && (y < 640).
  - press = btn && !btn_prev. Then btn_prev <= btn.
  - If in_grid, go to DIV_X with rem = x and q = 0. Otherwise go to UPDATE.
- DIV_X, one iteration per cycle:
  - If rem >= CELL_W: rem -= CELL_W and q++.
  - Otherwise store col = q, load rem = y and q = 0, and go to DIV_Y.
  - The state takes col+1 cycles.
- DIV_Y: same iteration with CELL_H. Stores row and goes to UPDATE. Takes row+1 cycles.
- UPDATE:
  - hover_valid_out <= in_grid.
  - If in_grid, also write hover_col_out and hover_row_out. If out of grid, col and row hold their previous values.
  - If press && in_grid: load click_col_out and click_row_out, set click_valid_out, and go to CLICK.
  - Otherwise go to IDLE.
- CLICK:
  - click_valid_out and click_col_out/click_row_out stay stable until click_ready_in is sampled high.
  - On that edge, clear click_valid_out and go to IDLE.
  - No new position sample is accepted while in CLICK.
- A press sample that is out of grid is discarded. btn_prev is still updated.
- A button held across consecutive samples produces exactly one click.
- Divider width: rem is 10 bits and q is 4 bits. The q limit is guaranteed by the in_grid check, so there is no overflow path.

## Timing
- Reset, asynchronous and applicable mid-operation:
  - state = IDLE, so pos_ready_out = 1.
  - All other outputs = 0.
  - btn_prev = 0, so a button already held at the first sample after reset counts as a press.
  - A pending click is lost.
- Let E0 be the accept edge.
  - In-grid: hover outputs and click_valid_out update at E0 + col + row + 3.
  - Out-of-grid: they update at E0 + 1.
- pos_ready_out returns high on the cycle after UPDATE with no click, or on the cycle after the click handshake.
- Best-case throughput: one sample every 4 cycles in grid, one every 2 cycles out of grid.
- click_ready_in high in the same cycle click_valid_out rises: the handshake completes on that edge.

## Structure
- Package cell_grid_pkg holds:
  - CELL_W, CELL_H, GRID_COLS, GRID_ROWS.
  - Derived X_LIMIT and Y_LIMIT.
  - Coordinate width (10) and index width (4).
  - The state enum.
- Sub-module cell_axis_div holds the one shared subtract-compare stage: rem and q registers, divisor select, and a done flag. Its divisor is muxed between CELL_W and CELL_H by the FSM.

## Test plan
- Reset released, no traffic -> pos_ready_out = 1; hover and click outputs all 0.
- Accept (0,0), btn = 0 -> hover col 0, row 0, valid 1 at E0 + 3; no click; pos_ready_out high at E0 + 4.
- Accept (479,639) -> hover col 9, row 9 at E0 + 21.
- Accept (480,10) after an in-grid sample -> hover_valid_out = 0 at E0 + 1; col and row unchanged.
- Accept (100,130), btn = 1 after btn = 0, click_ready_in low for 5 cycles:
  - click_valid_out rises with col 2, row 2 and holds.
  - pos_ready_out stays 0 until the handshake.
  - pos_ready_out returns to 1 one cycle after the handshake.
- Two samples with btn = 1 -> exactly one click.
- rst_n_in pulsed low during DIV_Y -> immediate IDLE, outputs 0, no click issued.
